// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Converts a 14-bit binary value to four BCD digits with a sequential
// double-dabble engine, then time-multiplexes the digits onto a shared
// BCD-to-7-segment decoder with active-low anode selects.
//
// Handshake: load is a single-cycle strobe that is accepted only when
// busy=0. While busy=1 any load is dropped silently (no queueing, no
// error flag). busy stays high for exactly 15 cycles after acceptance.
// The conversion result becomes visible only at the COMMIT edge.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    // Current FSM state; kept as a plainly named signal so checkers can bind to it.
    state_t state_q;
    state_t state_d;

    logic [13:0] bin_q;
    logic [15:0] acc_q;
    logic [3:0]  iter_q;
    logic        ovf_pend_q;
    logic [15:0] disp_q;

    logic        do_capture;
    logic        do_step;
    logic        do_commit;
    logic [29:0] step_res;

    logic [CNT_W-1:0] scan_cnt_q;
    logic [1:0]       idx_q;
    logic [1:0]       next_idx;
    logic [3:0]       blank;
    logic [3:0]       shown_nib;

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    function automatic logic [29:0] dabble_step(input logic [15:0] acc, input logic [13:0] bin);
        logic [15:0] adj;
        logic [29:0] cat;
        for (int k = 0; k < 4; k++) begin
            adj[k*4 +: 4] = (acc[k*4 +: 4] >= 4'd5) ? acc[k*4 +: 4] + 4'd3 : acc[k*4 +: 4];
        end
        cat = {adj, bin};
        return cat << 1;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: 14 steps in CONVERT (iter 0..13), then one COMMIT cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (load) state_d = S_CONVERT;
            S_CONVERT: if (iter_q == 4'd13) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath controls.
    always_comb begin
        busy       = (state_q != S_IDLE);
        do_capture = (state_q == S_IDLE) && load;
        do_step    = (state_q == S_CONVERT);
        do_commit  = (state_q == S_COMMIT);
        step_res   = dabble_step(acc_q, bin_q);
    end

    // Conversion datapath: capture on accept, shift once per CONVERT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q      <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
        end else if (do_capture) begin
            bin_q      <= value;
            acc_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= (value > 14'd9999);
        end else if (do_step) begin
            acc_q      <= step_res[29:14];
            bin_q      <= step_res[13:0];
            iter_q     <= iter_q + 4'd1;
        end
    end

    // Displayed digits and overflow flag change only at COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q   <= '0;
            overflow <= 1'b0;
        end else if (do_commit) begin
            if (ovf_pend_q) begin
                disp_q   <= 16'hFFFF;
                overflow <= 1'b1;
            end else begin
                disp_q   <= acc_q;
                overflow <= 1'b0;
            end
        end
    end

    // Leading-zero blanking: a digit blanks when it and every higher digit are zero.
    always_comb begin
        blank[3]  = BLANK_LZ && (disp_q[15:12] == 4'd0);
        blank[2]  = blank[3] && (disp_q[11:8] == 4'd0);
        blank[1]  = blank[2] && (disp_q[7:4] == 4'd0);
        blank[0]  = 1'b0;
        next_idx  = idx_q + 2'd1;
        shown_nib = blank[next_idx] ? 4'hF : disp_q[next_idx*4 +: 4];
    end

    // Free-running scan: on wrap, advance the digit and register anode/nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an         <= 4'b1110;
            bcd_out    <= 4'h0;
        end else if (scan_cnt_q == CNT_MAX) begin
            scan_cnt_q <= '0;
            idx_q      <= next_idx;
            an         <= ~(4'b0001 << next_idx);
            bcd_out    <= shown_nib;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

endmodule
